// File: rtl/down_cnt16.sv
// down_cnt16: loadable down counter with wrap (free-running) and one-shot modes.
// All state changes on the falling edge of ck; reset is synchronous and active-high.
module down_cnt16 #(
  parameter int WIDTH = 4
) (
  input  logic             ck,
  input  logic             res,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             mode,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             bo,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             bo_q, bo_d;
  logic             done_q, done_d;

  // Next-state and next-output logic: a load beats counting, and counting only happens in RUN.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    mode_d  = mode_q;
    bo_d    = 1'b0;
    done_d  = 1'b0;

    if (ld) begin
      q_d    = d;
      mode_d = mode;
      if (mode && (d == ZERO)) begin
        state_d = HALT;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if ((state_q == RUN) && en) begin
      if (q_q == ZERO) begin
        if (!mode_q) begin
          q_d  = ALL_ONES;
          bo_d = 1'b1;
        end else begin
          // A one-shot run never reaches zero while still in RUN; park safely if it does.
          state_d = HALT;
        end
      end else if (mode_q && (q_q == ONE)) begin
        q_d     = ZERO;
        done_d  = 1'b1;
        state_d = HALT;
      end else begin
        q_d = q_q - ONE;
      end
    end

    busy_d = (state_d == RUN);
  end

  // State and output registers, updated on the falling edge; reset overrides load and enable.
  always_ff @(negedge ck) begin
    if (res) begin
      state_q <= IDLE;
      q_q     <= ZERO;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      bo_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      bo_q    <= bo_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign busy = busy_q;
  assign bo   = bo_q;
  assign done = done_q;

endmodule

// File: tb/tb_down_cnt16.sv
// tb_down_cnt16: directed vectors pushed into a scoreboard queue, checked by an
// independent monitor after every falling edge of ck.
module tb_down_cnt16;

  localparam int WIDTH = 4;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             bo;
    logic             done;
  } exp_t;

  logic             ck = 1'b0;
  logic             res = 1'b0;
  logic             ld = 1'b0;
  logic [WIDTH-1:0] d = '0;
  logic             mode = 1'b0;
  logic             en = 1'b0;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             bo;
  logic             done;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   n_pushed = 0;
  int   n_popped = 0;

  down_cnt16 #(.WIDTH(WIDTH)) dut (
    .ck   (ck),
    .res  (res),
    .ld   (ld),
    .d    (d),
    .mode (mode),
    .en   (en),
    .q    (q),
    .busy (busy),
    .bo   (bo),
    .done (done)
  );

  // Clock: falling edges at 10, 20, ...; stimulus changes on rising edges.
  always #5 ck = ~ck;

  // Compare one observed field against its expected value.
  task automatic checkOutput(input string name, input int act, input int exp_v, input int vec);
    n_checks++;
    if (act !== exp_v) begin
      n_fails++;
      $display("[TB] FAIL %s vec=%0d actual=%0d required=%0d", name, vec, act, exp_v);
    end
  endtask

  // Drive one edge's inputs away from the active edge and queue the expected response.
  task automatic applyStimulus(input logic r, input logic l, input logic [WIDTH-1:0] dv,
                               input logic m, input logic e,
                               input logic [WIDTH-1:0] eq, input logic eb,
                               input logic ebo, input logic edn);
    exp_t x;
    @(posedge ck);
    res  = r;
    ld   = l;
    d    = dv;
    mode = m;
    en   = e;
    x.q    = eq;
    x.busy = eb;
    x.bo   = ebo;
    x.done = edn;
    sb_q.push_back(x);
    n_pushed++;
  endtask

  // Monitor: after each falling edge, pop the pending expectation and compare all outputs.
  initial begin
    exp_t x;
    forever begin
      @(negedge ck);
      #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        checkOutput("q",    int'(q),    int'(x.q),    n_popped);
        checkOutput("busy", int'(busy), int'(x.busy), n_popped);
        checkOutput("bo",   int'(bo),   int'(x.bo),   n_popped);
        checkOutput("done", int'(done), int'(x.done), n_popped);
        n_popped++;
      end
    end
  end

  // Directed sequence: r, ld, d, mode, en -> q, busy, bo, done
  initial begin
    int guard;
    // Reset, then reset winning over load and enable, then enable ignored in IDLE
    applyStimulus(1, 0, 0,  0, 0,  0, 0, 0, 0);
    applyStimulus(1, 1, 9,  1, 1,  0, 0, 0, 0);
    applyStimulus(0, 0, 0,  0, 1,  0, 0, 0, 0);
    // Wrap: load 2, count 1, 0, 15 (borrow), 14
    applyStimulus(0, 1, 2,  0, 0,  2, 1, 0, 0);
    applyStimulus(0, 0, 0,  0, 1,  1, 1, 0, 0);
    applyStimulus(0, 0, 0,  0, 1,  0, 1, 0, 0);
    applyStimulus(0, 0, 0,  0, 1, 15, 1, 1, 0);
    applyStimulus(0, 0, 0,  0, 1, 14, 1, 0, 0);
    // One-shot: load 3, count 2, 1, 0 (done), then held in HALT
    applyStimulus(0, 1, 3,  1, 0,  3, 1, 0, 0);
    applyStimulus(0, 0, 0,  0, 1,  2, 1, 0, 0);
    applyStimulus(0, 0, 0,  0, 1,  1, 1, 0, 0);
    applyStimulus(0, 0, 0,  0, 1,  0, 0, 0, 1);
    applyStimulus(0, 0, 0,  0, 1,  0, 0, 0, 0);
    applyStimulus(0, 0, 0,  0, 1,  0, 0, 0, 0);
    // Enable gaps: load 5, en 1,0,0,1
    applyStimulus(0, 1, 5,  0, 0,  5, 1, 0, 0);
    applyStimulus(0, 0, 0,  0, 1,  4, 1, 0, 0);
    applyStimulus(0, 0, 0,  0, 0,  4, 1, 0, 0);
    applyStimulus(0, 0, 0,  0, 0,  4, 1, 0, 0);
    applyStimulus(0, 0, 0,  0, 1,  3, 1, 0, 0);
    // Load over count: at q=7 with en=1, load 12 takes effect without decrement
    applyStimulus(0, 1, 8,  0, 0,  8, 1, 0, 0);
    applyStimulus(0, 0, 0,  0, 1,  7, 1, 0, 0);
    applyStimulus(0, 1, 12, 0, 1, 12, 1, 0, 0);
    applyStimulus(0, 0, 0,  0, 1, 11, 1, 0, 0);
    // Reset at q=6 together with load 9; subsequent enables leave q at 0
    applyStimulus(0, 1, 7,  0, 0,  7, 1, 0, 0);
    applyStimulus(0, 0, 0,  0, 1,  6, 1, 0, 0);
    applyStimulus(1, 1, 9,  0, 1,  0, 0, 0, 0);
    applyStimulus(0, 0, 0,  0, 1,  0, 0, 0, 0);
    applyStimulus(0, 0, 0,  0, 1,  0, 0, 0, 0);
    // Reset mid one-shot run at q=1 aborts without done
    applyStimulus(0, 1, 2,  1, 0,  2, 1, 0, 0);
    applyStimulus(0, 0, 0,  0, 1,  1, 1, 0, 0);
    applyStimulus(1, 0, 0,  0, 1,  0, 0, 0, 0);
    // Zero load one-shot: done on the load edge, HALT ignores enable
    applyStimulus(0, 1, 0,  1, 1,  0, 0, 0, 1);
    applyStimulus(0, 0, 0,  0, 1,  0, 0, 0, 0);
    // Zero load wrap: runs, first enable wraps to 15 with borrow
    applyStimulus(0, 1, 0,  0, 1,  0, 1, 0, 0);
    applyStimulus(0, 0, 0,  0, 1, 15, 1, 1, 0);
    applyStimulus(0, 0, 0,  0, 1, 14, 1, 0, 0);
    // Mode input is only sampled on load: wrap mode persists despite mode=1
    applyStimulus(0, 1, 1,  0, 0,  1, 1, 0, 0);
    applyStimulus(0, 0, 0,  1, 1,  0, 1, 0, 0);
    applyStimulus(0, 0, 0,  1, 1, 15, 1, 1, 0);
    @(posedge ck);
    ld = 1'b0;
    en = 1'b0;
    res = 1'b0;

    guard = 0;
    while ((sb_q.size() > 0) && (guard < 20)) begin
      @(posedge ck);
      guard++;
    end
    @(posedge ck);
    n_checks++;
    if (n_popped != n_pushed) begin
      n_fails++;
      $display("[TB] FAIL drain actual=%0d required=%0d", n_popped, n_pushed);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
